full_mat_host_if: RTL

FULL_MAT_HOST_IF -- requirements
Module: full_mat_host_if

---
 rtl/full_mat_host_if.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/full_mat_host_if.sv
// Bus-slave front end for an NxN matrix unit: operand banks A/B, result bank R, CTRL/STATUS.
// Define FULL_MAT_HOST_IRQ_EN to build the completion interrupt (CTRL bit3 enables it).
module full_mat_host_if #(
    parameter int N    = 6,
    parameter int W    = 27,
    parameter int PIPE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               chipselect,
    input  logic               write,
    input  logic               read,
    input  logic [7:0]         address,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic               irq,
    output logic               fm_en,
    output logic               fm_rst,
    output logic               fm_mat_mode,
    output logic [N*N*W-1:0]   fm_dataa,
    output logic [N*N*W-1:0]   fm_datab,
    input  logic [N*N*W-1:0]   fm_result
);

    localparam int NN      = N * N;
    localparam int RUN_MAT = N + PIPE;
    localparam int RUN_PAR = 1 + PIPE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_CAPT,
        S_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [NN-1:0][W-1:0]   a_q, b_q, r_q;
    logic [15:0]            cnt;
    logic [15:0]            run_len;
    logic                   err;
    logic                   busy, done;
    logic                   irq_enable;
    logic                   wr, rd;
    logic [1:0]             region;
    logic [5:0]             off;
    logic                   in_bank;
    logic                   ctrl_wr, start_req, clr_req, ab_wr;
    logic [31:0]            rd_mux;
    logic                   unused;

    assign wr        = chipselect && write;
    assign rd        = chipselect && read;
    assign region    = address[7:6];
    assign off       = address[5:0];
    assign in_bank   = ({26'b0, off} < 32'(NN));
    assign ctrl_wr   = wr && (address == 8'hC0);
    assign start_req = ctrl_wr && writedata[0];
    // a start in the same word takes precedence over clear_done
    assign clr_req   = ctrl_wr && writedata[2] && !writedata[0];
    assign ab_wr     = wr && !region[1] && in_bank;

    assign busy    = (state == S_CLR) || (state == S_RUN) || (state == S_CAPT);
    assign done    = (state == S_DONE);
    assign fm_en   = (state == S_RUN);
    assign fm_rst  = !rst || (state == S_CLR);
    assign run_len = fm_mat_mode ? 16'(RUN_MAT) : 16'(RUN_PAR);

    assign fm_dataa = a_q;
    assign fm_datab = b_q;
    assign unused   = &{1'b0, writedata};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_req) state_nxt = S_CLR;
            S_CLR:  state_nxt = S_RUN;
            S_RUN:  if (cnt == run_len - 16'd1) state_nxt = S_CAPT;
            S_CAPT: state_nxt = S_DONE;
            S_DONE: begin
                if (start_req)    state_nxt = S_CLR;
                else if (clr_req) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            fm_mat_mode <= 1'b0;
            err         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_CLR)      cnt <= '0;
            else if (state == S_RUN) cnt <= cnt + 16'd1;
            if (start_req && !busy) fm_mat_mode <= writedata[1];
            if (busy && (ab_wr || start_req)) err <= 1'b1;
            else if (clr_req && !busy)        err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0;
            b_q <= '0;
            r_q <= '0;
        end else begin
            for (int i = 0; i < NN; i++) begin
                if (ab_wr && !busy && (off == 6'(i))) begin
                    if (region[0]) b_q[i] <= writedata[W-1:0];
                    else           a_q[i] <= writedata[W-1:0];
                end
            end
            if (state == S_CAPT) r_q <= fm_result;
        end
    end

    // read mux looks at pre-edge storage, so a same-cycle write returns the old value
    always_comb begin
        rd_mux = '0;
        case (region)
            2'd0: for (int i = 0; i < NN; i++) if (off == 6'(i)) rd_mux = 32'(a_q[i]);
            2'd1: for (int i = 0; i < NN; i++) if (off == 6'(i)) rd_mux = 32'(b_q[i]);
            2'd2: for (int i = 0; i < NN; i++) if (off == 6'(i)) rd_mux = 32'(r_q[i]);
            default: begin
                if (address == 8'hC1)      rd_mux = {29'b0, err, done, busy};
                else if (address == 8'hC0) rd_mux = {28'b0, irq_enable, 1'b0, fm_mat_mode, 1'b0};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    readdata <= '0;
        else if (rd) readdata <= rd_mux;
    end

`ifdef FULL_MAT_HOST_IRQ_EN
    // irq tracks the state being entered so it rises with DONE and drops with clear_done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_enable <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (ctrl_wr) irq_enable <= writedata[3];
            irq <= (state_nxt == S_DONE) && (ctrl_wr ? writedata[3] : irq_enable);
        end
    end
`else
    assign irq_enable = 1'b0;
    assign irq        = 1'b0;
`endif

endmodule
